fetch_pc_unit: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. It holds the program counter, selects the next PC from sequential, branch, or jump sources, and presents the fetch address to instruction memory. It also registers the fetched instruction into the IF/ID pipeline register, with stall and flush control. It consumes the word-aligned branch offset from the offset shifter (sign-extended immediate << 2) and forms the branch target internally.

---
 rtl/fetch_pc_unit_if.sv | 29 ++
 rtl/fetch_pc_unit.sv | 66 ++++++
 tb/tb_fetch_pc_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: redirect/hazard controls in, imem address and IF/ID register out.
// The master modport is the surrounding pipeline; the slave modport is the fetch unit.
interface fetch_pc_unit_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_base;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] jump_base;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  modport master (
    output stall, flush, branch_taken, branch_base, branch_offset,
           jump, jump_index, jump_base, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid
  );

  modport slave (
    input  stall, flush, branch_taken, branch_base, branch_offset,
           jump, jump_index, jump_base, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// MIPS instruction-fetch slice: PC register with branch/jump/stall next-PC mux,
// followed by the IF/ID pipeline register with stall and flush control.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_pc_unit_if.slave bus
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;

  logic [31:0] w_pc4;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_pc_next;
  logic        w_redirect;
  logic        w_unused_jump_base;

  assign w_pc4           = r_pc + 32'd4;
  assign w_branch_target = bus.branch_base + bus.branch_offset;
  assign w_jump_target   = {bus.jump_base[31:28], bus.jump_index, 2'b00};
  assign w_redirect      = bus.branch_taken | bus.jump;
  assign w_unused_jump_base = ^bus.jump_base[27:0];

  // Branch beats jump (older instruction); any redirect beats stall.
  always_comb begin
    w_pc_next = w_pc4;
    if (bus.branch_taken) begin
      w_pc_next = w_branch_target;
    end else if (bus.jump) begin
      w_pc_next = w_jump_target;
    end else if (bus.stall) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_redirect || bus.flush) begin
        r_ifid_instr <= 32'd0;
        r_ifid_pc4   <= 32'd0;
        r_ifid_valid <= 1'b0;
      end else if (!bus.stall) begin
        r_ifid_instr <= bus.imem_rdata;
        r_ifid_pc4   <= w_pc4;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  assign bus.imem_addr  = r_pc;
  assign bus.ifid_instr = r_ifid_instr;
  assign bus.ifid_pc4   = r_ifid_pc4;
  assign bus.ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed test-plan scenarios with literal expectations,
// then random control traffic, all compared every cycle against a behavioural model.
module tb_fetch_pc_unit;

  logic clk;
  logic reset;
  fetch_pc_unit_if bus();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory returns the word address itself.
  assign bus.imem_rdata = bus.imem_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model of what the outputs must be.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  always @(posedge clk) begin
    logic [31:0] fetched_instr, fetched_pc4, new_pc;
    fetched_instr = m_pc;              // memory contents at the current PC
    fetched_pc4   = m_pc + 32'd4;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      if (bus.branch_taken)  new_pc = bus.branch_base + bus.branch_offset;
      else if (bus.jump)     new_pc = {bus.jump_base[31:28], bus.jump_index, 2'b00};
      else if (bus.stall)    new_pc = m_pc;
      else                   new_pc = fetched_pc4;
      if (bus.branch_taken || bus.jump || bus.flush) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!bus.stall) begin
        m_instr = fetched_instr; m_pc4 = fetched_pc4; m_valid = 1'b1;
      end
      m_pc = new_pc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_addr",  bus.imem_addr,  m_pc);
      chk("model_instr", bus.ifid_instr, m_instr);
      chk("model_pc4",   bus.ifid_pc4,   m_pc4);
      chk("model_valid", {31'd0, bus.ifid_valid}, {31'd0, m_valid});
    end
  end

  task automatic clear_inputs();
    reset = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
    bus.branch_base = 32'h0; bus.branch_offset = 32'h0;
    bus.jump_index = 26'h0; bus.jump_base = 32'h0;
  endtask

  // One clock edge, then settle past the negedge compare; inputs return to idle.
  task automatic step(input string tag);
    @(posedge clk);
    @(negedge clk);
    #2;
    clear_inputs();
    $display("%-14s addr=%h instr=%h pc4=%h valid=%b",
             tag, bus.imem_addr, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid);
  endtask

  task automatic expect_out(input string name, input logic [31:0] addr,
                            input logic [31:0] instr, input logic [31:0] pc4, input logic valid);
    chk({name, "_addr"},  bus.imem_addr,  addr);
    chk({name, "_instr"}, bus.ifid_instr, instr);
    chk({name, "_pc4"},   bus.ifid_pc4,   pc4);
    chk({name, "_valid"}, {31'd0, bus.ifid_valid}, {31'd0, valid});
  endtask

  task automatic do_branch(input logic [31:0] base, input logic [31:0] off);
    bus.branch_taken = 1'b1; bus.branch_base = base; bus.branch_offset = off;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b1;
    step("reset");
    check_en = 1'b1;
    expect_out("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    // Sequential fetch.
    step("seq1"); expect_out("seq1", 32'h4, 32'h0, 32'h4, 1'b1);
    step("seq2"); expect_out("seq2", 32'h8, 32'h4, 32'h8, 1'b1);
    step("seq3"); expect_out("seq3", 32'hC, 32'h8, 32'hC, 1'b1);
    step("seq4"); expect_out("seq4", 32'h10, 32'hC, 32'h10, 1'b1);

    // Backward branch at pc=0x10 to 0x04.
    do_branch(32'h0000_000C, 32'hFFFF_FFF8);
    step("branch"); expect_out("branch", 32'h4, 32'h0, 32'h0, 1'b0);
    step("br_tgt"); expect_out("br_tgt", 32'h8, 32'h4, 32'h8, 1'b1);

    // Jump, then jump with a simultaneous older branch.
    bus.jump = 1'b1; bus.jump_base = 32'hA000_0004; bus.jump_index = 26'h0000_040;
    step("jump"); expect_out("jump", 32'hA000_0100, 32'h0, 32'h0, 1'b0);
    bus.jump = 1'b1; bus.jump_base = 32'hA000_0004; bus.jump_index = 26'h0000_040;
    do_branch(32'h0000_0100, 32'h0000_0100);
    step("br_jump"); expect_out("br_jump", 32'h200, 32'h0, 32'h0, 1'b0);

    // Reach 0x20 with a valid instruction in IF/ID, then stall three cycles.
    bus.jump = 1'b1; bus.jump_base = 32'h0; bus.jump_index = 26'd7;
    step("jump1c");
    step("to20"); expect_out("to20", 32'h20, 32'h1C, 32'h20, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1;
      step("stall"); expect_out("stall", 32'h20, 32'h1C, 32'h20, 1'b1);
    end
    step("unstall"); expect_out("unstall", 32'h24, 32'h20, 32'h24, 1'b1);
    bus.stall = 1'b1; do_branch(32'h40, 32'h0);
    step("stall_br"); expect_out("stall_br", 32'h40, 32'h0, 32'h0, 1'b0);

    // Flush alone at 0x30, then stall & flush at 0x30.
    do_branch(32'h2C, 32'h0);
    step("to2c");
    step("to30");
    bus.flush = 1'b1;
    step("flush"); expect_out("flush", 32'h34, 32'h0, 32'h0, 1'b0);
    do_branch(32'h2C, 32'h0);
    step("to2c_b");
    step("to30_b"); expect_out("to30_b", 32'h30, 32'h2C, 32'h30, 1'b1);
    bus.stall = 1'b1; bus.flush = 1'b1;
    step("stall_fl"); expect_out("stall_fl", 32'h30, 32'h0, 32'h0, 1'b0);

    // PC wrap at the top of the address space.
    do_branch(32'hFFFF_FFFC, 32'h0);
    step("to_top"); expect_out("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    step("wrap");   expect_out("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Reset overriding a redirect.
    reset = 1'b1; bus.jump = 1'b1; bus.jump_index = 26'h3FF_FFFF;
    do_branch(32'h1234_5678, 32'h100);
    step("reset_redir"); expect_out("reset_redir", 32'h0, 32'h0, 32'h0, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #2;
      reset             = ($urandom_range(0, 199) == 0);
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.flush         = ($urandom_range(0, 9) == 0);
      bus.branch_taken  = ($urandom_range(0, 11) == 0);
      bus.jump          = ($urandom_range(0, 13) == 0);
      bus.branch_base   = $urandom;
      bus.branch_offset = {{14{1'b0}}, 18'($urandom)} << 2;
      if ($urandom_range(0, 1) == 1) bus.branch_offset = -bus.branch_offset;
      bus.jump_base     = $urandom;
      bus.jump_index    = 26'($urandom);
    end
    @(negedge clk);
    #2;
    clear_inputs();
    @(negedge clk);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
